hwpe_stream_deserialize_rr: RTL and testbench

- Receiving end of the serialized streaming protocol. Takes one serial HWPE stream and distributes its beats round-robin across NB_OUT_STREAMS parallel HWPE streams.
- Distribution is controlled by ctrl_serdes_t:
  - first_stream: starting output.
  - nb_contig_m1: contiguous beats per output, minus one.
  - clear_serdes_state: restarts the distribution.
- Sits between a TCDM-fed source and parallel engine inputs. It is the inverse of the serializer on the sink side.

---
 rtl/hwpe_stream_deserialize_rr.sv | 94 +++++++++
 tb/tb_hwpe_stream_deserialize_rr.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_deserialize_rr.sv
// Serial-to-parallel HWPE stream distributor: beats from one serial stream are
// dealt round-robin across NB_OUT_STREAMS lanes, nb_contig_m1+1 beats per lane.
module hwpe_stream_deserialize_rr #(
    parameter int unsigned NB_OUT_STREAMS = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
    localparam int unsigned IDX_W         = $clog2(NB_OUT_STREAMS)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clear_i,
    input  logic [20:0]                          ctrl_i,
    input  logic                                 push_valid_i,
    output logic                                 push_ready_o,
    input  logic [DATA_WIDTH-1:0]                push_data_i,
    input  logic [STRB_WIDTH-1:0]                push_strb_i,
    output logic [NB_OUT_STREAMS-1:0]            pop_valid_o,
    input  logic [NB_OUT_STREAMS-1:0]            pop_ready_i,
    output logic [NB_OUT_STREAMS*DATA_WIDTH-1:0] pop_data_o,
    output logic [NB_OUT_STREAMS*STRB_WIDTH-1:0] pop_strb_o,
    output logic [IDX_W-1:0]                     cur_stream_o,
    output logic                                 wrap_o
);

    typedef struct packed {
        logic [9:0] first_stream;
        logic       clear_serdes_state;
        logic [9:0] nb_contig_m1;
    } ctrl_serdes_t;

    ctrl_serdes_t     ctrl;
    logic [IDX_W-1:0] stream_idx;
    logic [9:0]       contig_cnt;
    logic [IDX_W-1:0] start_idx;
    logic             clear;
    logic             accept;
    logic             lane_done;
    logic             idx_last;

    assign ctrl      = ctrl_i;
    assign clear     = clear_i | ctrl.clear_serdes_state;
    assign start_idx = (11'(ctrl.first_stream) < 11'(NB_OUT_STREAMS))
                       ? ctrl.first_stream[IDX_W-1:0] : '0;

    // Valid/ready: a beat moves when push_valid_i & push_ready_o. Only the
    // selected lane sees valid, which never looks at any ready; clear blocks
    // the handshake in its own cycle so no beat can slip past a restart.
    always_comb begin
        pop_valid_o  = '0;
        push_ready_o = 1'b0;
        if (!clear) begin
            pop_valid_o[stream_idx] = push_valid_i;
            push_ready_o            = pop_ready_i[stream_idx];
        end
    end

    assign pop_data_o = {NB_OUT_STREAMS{push_data_i}};
    assign pop_strb_o = {NB_OUT_STREAMS{push_strb_i}};

    assign accept    = push_valid_i & push_ready_o;
    // Live >= compare: lowering nb_contig_m1 mid-lane moves on at the next beat.
    assign lane_done = (contig_cnt >= ctrl.nb_contig_m1);
    assign idx_last  = (stream_idx == IDX_W'(NB_OUT_STREAMS - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stream_idx <= '0;
            contig_cnt <= '0;
            wrap_o     <= 1'b0;
        end else if (clear) begin
            stream_idx <= start_idx;
            contig_cnt <= '0;
            wrap_o     <= 1'b0;
        end else begin
            wrap_o <= 1'b0;
            if (accept) begin
                if (lane_done) begin
                    contig_cnt <= '0;
                    if (idx_last) begin
                        stream_idx <= '0;
                        wrap_o     <= 1'b1;
                    end else begin
                        stream_idx <= stream_idx + 1'b1;
                    end
                end else begin
                    contig_cnt <= contig_cnt + 10'd1;
                end
            end
        end
    end

    assign cur_stream_o = stream_idx;

endmodule

// File: tb/tb_hwpe_stream_deserialize_rr.sv
// Bench for hwpe_stream_deserialize_rr: a 4-lane and a 3-lane instance share
// stimulus and are compared every cycle against a lane/run reference model.
module tb_hwpe_stream_deserialize_rr;

    localparam int DW = 32;
    localparam int SW = 4;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          clear;
    logic [9:0]    first_stream;
    logic          clr_bit;
    logic [9:0]    nb_m1;
    logic [20:0]   ctrl;
    logic          push_valid;
    logic [DW-1:0] push_data;
    logic [SW-1:0] push_strb;
    logic [3:0]    pop_ready;

    assign ctrl = {first_stream, clr_bit, nb_m1};

    logic          a_push_ready;
    logic [3:0]    a_pop_valid;
    logic [127:0]  a_pop_data;
    logic [15:0]   a_pop_strb;
    logic [1:0]    a_cur;
    logic          a_wrap;

    logic          b_push_ready;
    logic [2:0]    b_pop_valid;
    logic [95:0]   b_pop_data;
    logic [11:0]   b_pop_strb;
    logic [1:0]    b_cur;
    logic          b_wrap;

    hwpe_stream_deserialize_rr #(.NB_OUT_STREAMS(4), .DATA_WIDTH(DW)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .ctrl_i(ctrl),
        .push_valid_i(push_valid), .push_ready_o(a_push_ready),
        .push_data_i(push_data), .push_strb_i(push_strb),
        .pop_valid_o(a_pop_valid), .pop_ready_i(pop_ready),
        .pop_data_o(a_pop_data), .pop_strb_o(a_pop_strb),
        .cur_stream_o(a_cur), .wrap_o(a_wrap)
    );

    hwpe_stream_deserialize_rr #(.NB_OUT_STREAMS(3), .DATA_WIDTH(DW)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .ctrl_i(ctrl),
        .push_valid_i(push_valid), .push_ready_o(b_push_ready),
        .push_data_i(push_data), .push_strb_i(push_strb),
        .pop_valid_o(b_pop_valid), .pop_ready_i(pop_ready[2:0]),
        .pop_data_o(b_pop_data), .pop_strb_o(b_pop_strb),
        .cur_stream_o(b_cur), .wrap_o(b_wrap)
    );

    // reference model: current lane and beats already taken in it
    int m_nb[2] = '{4, 3};
    int m_lane[2];
    int m_run[2];
    int m_wrap[2];

    // scoreboard for the 4-lane instance: {lane, data} of each expected beat
    logic [33:0] exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_lane[d] = 0;
            m_run[d]  = 0;
            m_wrap[d] = 0;
        end
    endtask

    // one cycle: inputs already driven; compare at negedge, advance model, pass edge
    task automatic step();
        bit          clr;
        bit          acc[2];
        logic [3:0]  ev[2];
        bit          er[2];
        logic [33:0] got;
        @(negedge clk);
        clr = clear | clr_bit;
        for (int d = 0; d < 2; d++) begin
            ev[d]  = (clr || !push_valid) ? 4'd0 : 4'(1 << m_lane[d]);
            er[d]  = !clr && pop_ready[m_lane[d]];
            acc[d] = push_valid && er[d];
        end
        check("a_pop_valid", a_pop_valid, ev[0]);
        check("a_push_ready", a_push_ready, er[0]);
        check("a_cur_stream", a_cur, m_lane[0]);
        check("a_wrap", a_wrap, m_wrap[0]);
        check("a_data_bcast", a_pop_data, {4{push_data}});
        check("a_strb_bcast", a_pop_strb, {4{push_strb}});
        check("b_pop_valid", b_pop_valid, ev[1][2:0]);
        check("b_push_ready", b_push_ready, er[1]);
        check("b_cur_stream", b_cur, m_lane[1]);
        check("b_wrap", b_wrap, m_wrap[1]);
        check("b_data_bcast", b_pop_data, {3{push_data}});

        if (acc[0] && rst_n) exp_q.push_back({2'(m_lane[0]), push_data});
        for (int k = 0; k < 4; k++) begin
            if (a_pop_valid[k] && pop_ready[k] && rst_n) begin
                got = {2'(k), a_pop_data[k*DW +: DW]};
                if (exp_q.size() == 0) check("a_extra_beat", got, 34'd0);
                else check("a_beat", got, exp_q.pop_front());
            end
        end

        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_lane[d] = 0; m_run[d] = 0; m_wrap[d] = 0;
            end else if (clr) begin
                m_lane[d] = (int'(first_stream) < m_nb[d]) ? int'(first_stream) : 0;
                m_run[d]  = 0;
                m_wrap[d] = 0;
            end else begin
                m_wrap[d] = 0;
                if (acc[d]) begin
                    m_run[d]++;
                    if (m_run[d] > int'(nb_m1)) begin
                        m_run[d]  = 0;
                        m_lane[d] = (m_lane[d] + 1) % m_nb[d];
                        m_wrap[d] = (m_lane[d] == 0);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic do_clear(input int first, input int nb);
        first_stream = 10'(first);
        nb_m1        = 10'(nb);
        clr_bit      = 1'b1;
        step();
        clr_bit      = 1'b0;
    endtask

    task automatic push_beats(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            push_valid = 1'b1;
            push_data  = base + 32'(i);
            push_strb  = 4'(i);
            step();
        end
        push_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; clr_bit = 1'b0; first_stream = '0; nb_m1 = '0;
        push_valid = 1'b0; push_data = '0; push_strb = '0; pop_ready = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        step();
        rst_n = 1'b1;
        step();

        // plain per-beat round-robin
        do_clear(0, 0);
        push_beats(8, 32'hA0);
        step();

        // three beats per lane starting at lane 2
        do_clear(2, 2);
        push_beats(9, 32'hB0);
        step();

        // backpressure on lane 1, then release
        do_clear(1, 0);
        pop_ready  = 4'b1101;
        push_valid = 1'b1;
        push_data  = 32'hC1;
        repeat (5) step();
        pop_ready = 4'hF;
        step();
        push_valid = 1'b0;
        step();

        // clear mid-run with a beat pending
        do_clear(3, 1);
        push_beats(1, 32'hD0);
        push_valid   = 1'b1;
        first_stream = 10'd1;
        clr_bit      = 1'b1;
        step();
        clr_bit = 1'b0;
        push_beats(4, 32'hD8);

        // out-of-range first_stream and a 3-lane wrap
        do_clear(5, 0);
        push_beats(6, 32'hE0);
        step();

        // lowering nb_contig_m1 mid-lane
        do_clear(0, 7);
        push_beats(4, 32'hF0);
        nb_m1 = 10'd1;
        push_beats(6, 32'hF8);

        // maximum run length across a lane boundary
        do_clear(0, 1023);
        push_beats(1030, 32'h1000);

        // random traffic
        do_clear(0, 0);
        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            clear      = ($urandom_range(0, 49) == 0);
            clr_bit    = ($urandom_range(0, 49) == 0);
            first_stream = 10'($urandom_range(0, 6));
            if ($urandom_range(0, 99) == 0) nb_m1 = 10'($urandom_range(0, 5));
            push_valid = ($urandom_range(0, 3) != 0);
            push_data  = $urandom;
            push_strb  = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) pop_ready[k] = ($urandom_range(0, 4) != 0);
            step();
        end
        rst_n = 1'b1; clear = 1'b0; clr_bit = 1'b0; push_valid = 1'b0;
        step();

        check("a_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
